// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU: operation encodings and datapath widths.
package alu_pkg;

  localparam int XLEN         = 32;
  localparam int SHAMT_W      = 5;
  localparam int SRAI_IMM_BIT = 10;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_SLL    = 4'd5,
    OP_SRL    = 4'd6,
    OP_SRA    = 4'd7,
    OP_SLT    = 4'd8,
    OP_SLTU   = 4'd9,
    OP_PASS_B = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_compare.sv
// Operand comparator shared by branch resolution and the SLT/SLTU results.
module alu_compare
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            equal,
  output logic            less_than,
  output logic            less_than_unsigned
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = A;
  assign b_s = B;

  assign equal              = (A == B);
  assign less_than          = (a_s < b_s);
  assign less_than_unsigned = (A < B);

endmodule

// File: rtl/alu_core.sv
// Combinational RV32I ALU with compare flags; optional registered result copy
// enabled by defining ALU_RESULT_REG_EN.
module alu_core
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      alu_control,
  input  logic            alu_src,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] result,
  output logic            equal,
  output logic            less_than,
  output logic            less_than_unsigned,
  output logic [XLEN-1:0] result_q
);

  logic signed [XLEN-1:0] a_s;
  logic [SHAMT_W-1:0]     shamt;
  logic                   srai_sel;

  assign a_s   = A;
  assign shamt = B[SHAMT_W-1:0];
  // SRAI shares funct3 with SRLI; funct7[5] arrives in immediate bit 10.
  assign srai_sel = alu_src && B[SRAI_IMM_BIT];

  alu_compare u_compare (
    .A                  (A),
    .B                  (B),
    .equal              (equal),
    .less_than          (less_than),
    .less_than_unsigned (less_than_unsigned)
  );

  always_comb begin
    result = '0;
    case (alu_control)
      OP_ADD:    result = A + B;
      OP_SUB:    result = A - B;
      OP_AND:    result = A & B;
      OP_OR:     result = A | B;
      OP_XOR:    result = A ^ B;
      OP_SLL:    result = A << shamt;
      OP_SRL:    result = srai_sel ? XLEN'(a_s >>> shamt) : (A >> shamt);
      OP_SRA:    result = XLEN'(a_s >>> shamt);
      OP_SLT:    result = {{(XLEN-1){1'b0}}, less_than};
      OP_SLTU:   result = {{(XLEN-1){1'b0}}, less_than_unsigned};
      OP_PASS_B: result = B;
      default:   result = '0;
    endcase
  end

`ifdef ALU_RESULT_REG_EN
  // Trace copy of the execute result, one cycle behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = &{1'b0, clk, reset};
  assign result_q = '0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core (works with or without ALU_RESULT_REG_EN).
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic [3:0]  alu_control;
  logic        alu_src;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        equal;
  logic        less_than;
  logic        less_than_unsigned;
  logic [31:0] result_q;

  int passed;
  int total;

`ifdef ALU_RESULT_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  alu_core dut (
    .clk                (clk),
    .reset              (reset),
    .alu_control        (alu_control),
    .alu_src            (alu_src),
    .A                  (A),
    .B                  (B),
    .result             (result),
    .equal              (equal),
    .less_than          (less_than),
    .less_than_unsigned (less_than_unsigned),
    .result_q           (result_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apply(input logic [3:0] op, input logic src,
                       input logic [31:0] a, input logic [31:0] b);
    alu_control = op;
    alu_src     = src;
    A           = a;
    B           = b;
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    apply(4'd0, 1'b0, 32'd0, 32'd0);
    chk("reset_result_q", result_q, 32'h0);

    // ADD/SUB wrap
    @(negedge clk);
    reset = 1'b0;
    apply(4'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("add_wrap", result, 32'h0);
    apply(4'd1, 1'b0, 32'h0, 32'd1);
    chk("sub_wrap", result, 32'hFFFF_FFFF);

    // Signed vs unsigned compare
    apply(4'd8, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("lt_flag", {31'b0, less_than}, 32'd1);
    chk("ltu_flag", {31'b0, less_than_unsigned}, 32'd0);
    chk("eq_flag_ne", {31'b0, equal}, 32'd0);
    chk("slt", result, 32'd1);
    apply(4'd9, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", result, 32'd0);

    // Shift amount masking
    apply(4'd6, 1'b0, 32'h8000_0000, 32'h0000_0021);
    chk("srl_mask", result, 32'h4000_0000);
    apply(4'd7, 1'b0, 32'h8000_0000, 32'h0000_0021);
    chk("sra_mask", result, 32'hC000_0000);
    apply(4'd5, 1'b0, 32'h1, 32'h0000_0021);
    chk("sll_mask", result, 32'h2);

    // SRAI edge case
    apply(4'd6, 1'b1, 32'h8000_0000, 32'h0000_0404);
    chk("srai_imm", result, 32'hF800_0000);
    apply(4'd6, 1'b0, 32'h8000_0000, 32'h0000_0404);
    chk("srl_reg_b10", result, 32'h0800_0000);
    apply(4'd6, 1'b1, 32'h8000_0000, 32'h0000_0004);
    chk("srli_imm", result, 32'h0800_0000);

    // Logic, PASS_B, unused codes
    apply(4'd2, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("and", result, 32'h00F0_00F0);
    apply(4'd3, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("or", result, 32'hFFF0_FFF0);
    apply(4'd4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("xor", result, 32'hFF00_FF00);
    apply(4'd10, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("pass_b", result, 32'h0FF0_0FF0);
    apply(4'd13, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("unused_13", result, 32'h0);
    apply(4'd15, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("unused_15", result, 32'h0);

    // Flags with equal operands, under an unrelated op
    apply(4'd4, 1'b1, 32'd7, 32'd7);
    chk("eq_flag", {31'b0, equal}, 32'd1);
    chk("lt_flag_eq", {31'b0, less_than}, 32'd0);
    chk("ltu_flag_eq", {31'b0, less_than_unsigned}, 32'd0);

    // Register path
    @(negedge clk);
    apply(4'd0, 1'b0, 32'd3, 32'd4);
    chk("add_comb", result, 32'd7);
    @(posedge clk);
    #1;
    chk("result_q_capture", result_q, REG_EN ? 32'd7 : 32'd0);

    // Asynchronous reset mid-cycle, no clock edge in between
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("result_q_async_rst", result_q, 32'h0);
    chk("result_during_rst", result, 32'd7);
    @(posedge clk);
    #1;
    chk("result_q_hold_rst", result_q, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    apply(4'd1, 1'b0, 32'd10, 32'd4);
    @(posedge clk);
    #1;
    chk("result_q_after_rst", result_q, REG_EN ? 32'd6 : 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
